// File: rtl/mant_div_pkg.sv
// Shared definitions for the posit FMAU mantissa divider.
//   MANT_W / LANE_W : full-lane and split-lane mantissa widths
//   OP_*            : op encodings (00/01 full lane, 10/11 dual lane)
//   state_t         : divider control states
//   is_split()      : decodes op into the dual-lane flag
package mant_div_pkg;

  localparam int MANT_W = 28;
  localparam int LANE_W = 14;

  localparam logic [1:0] OP_FULL0  = 2'b00;
  localparam logic [1:0] OP_FULL1  = 2'b01;
  localparam logic [1:0] OP_SPLIT0 = 2'b10;
  localparam logic [1:0] OP_SPLIT1 = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic logic is_split(input logic [1:0] op);
    case (op)
      OP_FULL0, OP_FULL1:   return 1'b0;
      OP_SPLIT0, OP_SPLIT1: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mant_div_step.sv
// One restoring-division iteration: conditional subtract, then shift left.
//   ct       : 1 = dual 14-bit lanes, cuts borrow and shift at bit 15
//   rem_in   : remainder (full: [28:0]; split: lane1 [29:15], lane0 [14:0])
//   div_in   : divisor, same layout as rem_in
//   rem_diff : remainder after the conditional subtract (before the shift)
//   rem_out  : remainder for the next iteration (rem_diff shifted left)
//   qbit     : quotient bits; [0] = lane0 or full lane, [1] = lane1
module mant_div_step
  import mant_div_pkg::*;
(
  input  logic                  ct,
  input  logic [2*LANE_W+1:0]   rem_in,
  input  logic [2*LANE_W+1:0]   div_in,
  output logic [2*LANE_W+1:0]   rem_diff,
  output logic [2*LANE_W+1:0]   rem_out,
  output logic [1:0]            qbit
);

  localparam int HW = LANE_W + 1;

  logic [HW:0] lo_sum;
  logic [HW:0] hi_sum;
  logic        hi_cin;
  logic        ge0;
  logic        ge1;

  // A single 30-bit subtractor built from two 15-bit halves. In full mode the
  // low half's carry feeds the high half; in split mode the carry-in is forced
  // to 1 so each half is an independent r - d. Carry out == (r >= d).
  always_comb begin
    lo_sum = {1'b0, rem_in[HW-1:0]} + {1'b0, ~div_in[HW-1:0]} + {{HW{1'b0}}, 1'b1};
    hi_cin = ct ? 1'b1 : lo_sum[HW];
    hi_sum = {1'b0, rem_in[2*HW-1:HW]} + {1'b0, ~div_in[2*HW-1:HW]} + {{HW{1'b0}}, hi_cin};

    ge1 = hi_sum[HW];
    ge0 = ct ? lo_sum[HW] : hi_sum[HW];

    rem_diff[2*HW-1:HW] = ge1 ? hi_sum[HW-1:0] : rem_in[2*HW-1:HW];
    rem_diff[HW-1:0]    = ge0 ? lo_sum[HW-1:0] : rem_in[HW-1:0];

    // In split mode lane0's top bit must not shift into lane1.
    rem_out = {rem_diff[2*HW-2:HW], ct ? 1'b0 : rem_diff[HW-1],
               rem_diff[HW-2:0], 1'b0};
    qbit    = {ge1, ge0};
  end

endmodule

// File: rtl/mantissa_divider_28.sv
// Iterative radix-2 restoring mantissa divider (28-bit or dual 14-bit lanes).
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : operand handshake (in_ready only in IDLE)
//   op                 : 00/01 full lane, 10/11 dual 14-bit lanes
//   dividend, divisor  : mantissas; split mode lane1 = [27:14], lane0 = [13:0]
//   out_valid/out_ready: result handshake (results held while stalled)
//   quot               : truncated quotient, same lane layout as operands
//   sticky             : remainder nonzero per lane ([1] = 0 in full mode)
//   dz                 : divide-by-zero per lane ([1] = 0 in full mode)
module mantissa_divider_28
  import mant_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [MANT_W-1:0] dividend,
  input  logic [MANT_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] quot,
  output logic [1:0]        sticky,
  output logic [1:0]        dz
);

  localparam int REM_W = 2 * LANE_W + 2;

  state_t             state;
  state_t             state_nxt;
  logic               split_r;
  logic [REM_W-1:0]   rem_r;
  logic [REM_W-1:0]   div_r;
  logic [MANT_W-2:0]  qacc;
  logic [4:0]         cnt;
  logic [1:0]         dz_r;

  logic               acc_split;
  logic [REM_W-1:0]   acc_rem;
  logic [REM_W-1:0]   acc_div;
  logic [1:0]         acc_dz;
  logic               acc_bypass;
  logic               pre_ok;

  logic [REM_W-1:0]   step_diff;
  logic [REM_W-1:0]   step_rem;
  logic [1:0]         step_q;
  logic [MANT_W-1:0]  q_next;
  logic [MANT_W-1:0]  q_fin;
  logic [1:0]         st_fin;

  mant_div_step u_step (
    .ct       (split_r),
    .rem_in   (rem_r),
    .div_in   (div_r),
    .rem_diff (step_diff),
    .rem_out  (step_rem),
    .qbit     (step_q)
  );

  // Operand decode at accept: place lanes into the 30-bit remainder layout
  // with a guard bit above each lane, and flag zero divisors.
  always_comb begin
    acc_split = is_split(op);
    if (acc_split) begin
      acc_rem    = {1'b0, dividend[MANT_W-1:LANE_W], 1'b0, dividend[LANE_W-1:0]};
      acc_div    = {1'b0, divisor[MANT_W-1:LANE_W], 1'b0, divisor[LANE_W-1:0]};
      acc_dz     = {divisor[MANT_W-1:LANE_W] == '0, divisor[LANE_W-1:0] == '0};
      acc_bypass = &acc_dz;
      pre_ok     = (acc_dz[1] || ({1'b0, dividend[MANT_W-1:LANE_W]} < {divisor[MANT_W-1:LANE_W], 1'b0}))
                && (acc_dz[0] || ({1'b0, dividend[LANE_W-1:0]} < {divisor[LANE_W-1:0], 1'b0}));
    end else begin
      acc_rem    = {2'b00, dividend};
      acc_div    = {2'b00, divisor};
      acc_dz     = {1'b0, divisor == '0};
      acc_bypass = acc_dz[0];
      pre_ok     = acc_dz[0] || ({1'b0, dividend} < {divisor, 1'b0});
    end
  end

  // The last quotient bit arrives in the same cycle the result is latched,
  // so the final value is assembled from the accumulator plus this step.
  always_comb begin
    if (split_r) begin
      q_next = {qacc[MANT_W-2:LANE_W], step_q[1], qacc[LANE_W-2:0], step_q[0]};
      q_fin  = {dz_r[1] ? {LANE_W{1'b1}} : q_next[MANT_W-1:LANE_W],
                dz_r[0] ? {LANE_W{1'b1}} : q_next[LANE_W-1:0]};
      st_fin = {~dz_r[1] & (|step_diff[REM_W-1:LANE_W+1]),
                ~dz_r[0] & (|step_diff[LANE_W:0])};
    end else begin
      q_next = {qacc, step_q[0]};
      q_fin  = dz_r[0] ? {MANT_W{1'b1}} : q_next;
      st_fin = {1'b0, ~dz_r[0] & (|step_diff)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)       state_nxt = acc_bypass ? DONE : CALC;
      CALC: if (cnt == 5'd0)    state_nxt = DONE;
      DONE: if (out_ready)      state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      split_r <= 1'b0;
      rem_r   <= '0;
      div_r   <= '0;
      qacc    <= '0;
      cnt     <= '0;
      dz_r    <= '0;
      quot    <= '0;
      sticky  <= '0;
      dz      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            split_r <= acc_split;
            rem_r   <= acc_rem;
            div_r   <= acc_div;
            dz_r    <= acc_dz;
            qacc    <= '0;
            cnt     <= acc_split ? 5'(LANE_W - 1) : 5'(MANT_W - 1);
            if (acc_bypass) begin
              quot   <= '1;
              sticky <= '0;
              dz     <= acc_dz;
            end
          end
        end
        CALC: begin
          rem_r <= step_rem;
          qacc  <= q_next[MANT_W-2:0];
          cnt   <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            quot   <= q_fin;
            sticky <= st_fin;
            dz     <= dz_r;
          end
        end
        default: ;
      endcase
    end
  end

  // Normalized operands guarantee A < 2B per non-zero lane.
  assert property (@(posedge clk) disable iff (rst) (in_valid && in_ready) |-> pre_ok);

endmodule

// File: doc/mantissa_divider_28.md
Name: mantissa_divider_28

Overview:
- Iterative radix-2 restoring mantissa divider for the posit FMAU datapath. It is the division counterpart of the 28x28 mantissa multiplier tree.
- Accepts normalized dividend and divisor mantissas through a valid/ready handshake. Produces the truncated quotient plus sticky and divide-by-zero flags.
- Supports the same op-driven lane split as the multiplier:
  - op 00/01: one 28-bit lane.
  - op 10/11: two independent 14-bit lanes, split at bit 14.

Parameters:
- MANT_W, 28, full-lane mantissa width. Fixed; the split lanes are MANT_W/2.
- LANE_W, 14, split-lane width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  divider idle and accepting
- op  in  2  mode: 00/01 full 28-bit, 10/11 dual 14-bit
- dividend  in  28  mantissa A; split mode: lane1=[27:14], lane0=[13:0]
- divisor  in  28  mantissa B; same lane layout as dividend
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quot  out  28  quotient; split mode uses the same lane layout as the operands
- sticky  out  2  remainder nonzero; [0]=lane0 (or full lane), [1]=lane1 (0 in full mode)
- dz  out  2  divide-by-zero per lane; same bit mapping as sticky

Behaviour:
- Reset: all outputs and internal state are cleared in IDLE: in_ready=1, out_valid=0, quot=0, sticky=0, dz=0. An assertion mid-operation aborts the operation immediately and drops any pending result.
- Precondition: per lane, A < 2B (normalized, hidden bit set). The bench must not violate it. The RTL carries an assertion for it; the result is unspecified if it is violated.
- Function, full mode: quot = floor(A * 2^27 / B); sticky[0] = (A * 2^27 mod B) != 0.
- Function, split mode: per lane, q = floor(A_l * 2^13 / B_l); sticky = remainder != 0.
- Algorithm:
  - Remainder R is 29 bits in full mode, or 2 x 15 bits in split mode. It starts at A.
  - Each iteration: if R >= B, set q_i=1 and R=R-B; then R = R<<1.
  - The MSB quotient bit is produced first.
  - In split mode, a ct cut blocks borrow/shift crossing between lanes.
- Handshake in: a transfer occurs when in_valid && in_ready. in_ready=1 only in IDLE. Operands and op are registered on acceptance.
- States:
  - IDLE: on accept, go to CALC, or to DONE if every active lane has B=0.
  - CALC: one iteration per cycle. The counter loads N-1, where N=28 (full) or 14 (split). At count 0, latch the results and go to DONE.
  - DONE: out_valid=1. Go to IDLE when out_ready=1.
- Latency: out_valid rises N+1 cycles after the accept edge. For the all-zero-divisor bypass it rises 1 cycle after.
- Throughput: no new accept while in CALC or DONE. The earliest next accept is the cycle after out_valid && out_ready, when in_ready returns high.
- Output stability: quot, sticky and dz are held stable while out_valid=1 && out_ready=0. out_ready has no effect outside DONE.
- Divide by zero: a lane with B=0 sets its dz bit, forces its quotient bits all ones and sets sticky=0.
  - In split mode, one zero lane does not shorten latency; the other lane computes normally.
- op values 00 and 01 are equivalent, as are 10 and 11. op is sampled only on accept.

Decomposition:
- Shared package (mant_div_pkg):
  - MANT_W=28, LANE_W=14.
  - OP_FULL0=2'b00, OP_FULL1=2'b01, OP_SPLIT0=2'b10, OP_SPLIT1=2'b11.
  - Helper function is_split(op).
  - State enum {IDLE, CALC, DONE}.
- Sub-module mant_div_step: combinational conditional-subtract-and-shift over the 30-bit remainder/divisor pair.
  - ct input cuts borrow and shift at the lane boundary.
  - Outputs 2 quotient bits: [1] unused in full mode.
  - The top level owns the FSM, counter, registers and handshake.

Test Plan:
- Full, A=0x8000000, B=0x8000000 -> after 29 cycles quot=0x8000000, sticky=00, dz=00.
- Full, A=0x8000000, B=0xC000000 -> quot=0x5555555, sticky=01, dz=00.
- Full, A=0xFFFFFFF, B=0x8000000 -> quot=0xFFFFFFF, sticky=00.
- Split (op=10), lane1 A=0x2000, B=0x3000; lane0 A=0x3FFF, B=0x2000 -> after 15 cycles quot={0x1555,0x3FFF}, sticky=10.
- Split, lane0 B=0, lane1 A=B=0x2000 -> quot={0x2000,0x3FFF}, dz=01, sticky=00, 15 cycles. Full mode B=0 -> quot=0xFFFFFFF, dz=01, out_valid 1 cycle after accept.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
  - Assert rst at iteration 10 -> next cycle in_ready=1, out_valid=0.
  - A fresh operation then completes correctly.
